// File: rtl/bless_sw_traversal_if.sv
// ---------------------------------------------------------------------------
// bless_sw_traversal_if
//   Bundle of all non-clock/reset signals of the BLESS switch-traversal stage.
//
//   Inputs (driven by the allocator side, modport master):
//     flit_in_0..3   : flits of the four rank-ordered channels (0 = highest)
//     valid_in_0..3  : channel carries a flit
//     mc_0..3        : channel flit is multicast
//     ppv_0..3       : productive ports, bit0=N, bit1=E, bit2=S, bit3=W
//     allocPV_0..3   : ports granted to the channel by the allocator
//     stat_clr       : synchronous clear of statistics counters and error flags
//   Outputs (driven by the stage, modport slave):
//     flit_out_0..3  : registered flit on output link N/E/S/W
//     valid_out_0..3 : registered link valid
//     defl_out_0..3  : registered, link carries a deflected copy
//     cnt_fwd        : saturating count of copies sent on all links
//     cnt_defl       : saturating count of deflected copies sent
//     err_conflict   : sticky, two channels granted the same port
//     err_drop       : sticky, valid channel granted no port
//     err_mc_split   : sticky, unicast channel granted more than one port
//
//   Handshake: valid_in_*/valid_out_* are pure qualifiers. There is no ready
//   signal and no backpressure; a new input set is consumed every clock and
//   the corresponding outputs are valid exactly one clock later.
// ---------------------------------------------------------------------------
interface bless_sw_traversal_if #(
  parameter int FLIT_W = 64,
  parameter int CNT_W  = 16
);
  logic [FLIT_W-1:0] flit_in_0, flit_in_1, flit_in_2, flit_in_3;
  logic              valid_in_0, valid_in_1, valid_in_2, valid_in_3;
  logic              mc_0, mc_1, mc_2, mc_3;
  logic [3:0]        ppv_0, ppv_1, ppv_2, ppv_3;
  logic [3:0]        allocPV_0, allocPV_1, allocPV_2, allocPV_3;
  logic              stat_clr;

  logic [FLIT_W-1:0] flit_out_0, flit_out_1, flit_out_2, flit_out_3;
  logic              valid_out_0, valid_out_1, valid_out_2, valid_out_3;
  logic              defl_out_0, defl_out_1, defl_out_2, defl_out_3;
  logic [CNT_W-1:0]  cnt_fwd, cnt_defl;
  logic              err_conflict, err_drop, err_mc_split;

  modport slave (
    input  flit_in_0, flit_in_1, flit_in_2, flit_in_3,
    input  valid_in_0, valid_in_1, valid_in_2, valid_in_3,
    input  mc_0, mc_1, mc_2, mc_3,
    input  ppv_0, ppv_1, ppv_2, ppv_3,
    input  allocPV_0, allocPV_1, allocPV_2, allocPV_3,
    input  stat_clr,
    output flit_out_0, flit_out_1, flit_out_2, flit_out_3,
    output valid_out_0, valid_out_1, valid_out_2, valid_out_3,
    output defl_out_0, defl_out_1, defl_out_2, defl_out_3,
    output cnt_fwd, cnt_defl,
    output err_conflict, err_drop, err_mc_split
  );

  modport master (
    output flit_in_0, flit_in_1, flit_in_2, flit_in_3,
    output valid_in_0, valid_in_1, valid_in_2, valid_in_3,
    output mc_0, mc_1, mc_2, mc_3,
    output ppv_0, ppv_1, ppv_2, ppv_3,
    output allocPV_0, allocPV_1, allocPV_2, allocPV_3,
    output stat_clr,
    input  flit_out_0, flit_out_1, flit_out_2, flit_out_3,
    input  valid_out_0, valid_out_1, valid_out_2, valid_out_3,
    input  defl_out_0, defl_out_1, defl_out_2, defl_out_3,
    input  cnt_fwd, cnt_defl,
    input  err_conflict, err_drop, err_mc_split
  );
endinterface

// File: rtl/bless_sw_traversal.sv
// ---------------------------------------------------------------------------
// bless_sw_traversal
//   Switch-traversal stage behind the BLESS multicast port allocator. Steers
//   and replicates the four rank-ordered channel flits through a 4x4 crossbar
//   onto the N/E/S/W links, bumps the deflection-count header field of copies
//   sent to a non-productive port, and registers the result (1 cycle latency).
//   Also keeps saturating copy/deflection counters and sticky error flags.
//
//   Ports:
//     clk   : stage clock
//     reset : asynchronous, active-low reset (all flops cleared, incl. flits)
//     bus   : bless_sw_traversal_if.slave, see the interface for signal list
//
//   FLIT_W / CNT_W must match the parameters of the connected interface.
// ---------------------------------------------------------------------------
module bless_sw_traversal #(
  parameter int FLIT_W   = 64,
  parameter int DEFL_LSB = 56,
  parameter int DEFL_W   = 4,
  parameter int CNT_W    = 16
) (
  input logic                 clk,
  input logic                 reset,
  bless_sw_traversal_if.slave bus
);

  localparam int NCH = 4;
  localparam int NP  = 4;
  localparam logic [DEFL_W-1:0]  DEFL_ONE = 1;
  localparam logic [NP-1:0]      PV_ONE   = 1;
  localparam logic [CNT_W+2:0]   CNT_SAT  = {3'b000, {CNT_W{1'b1}}};

  // Input views as arrays
  logic [FLIT_W-1:0] flit_in [NCH];
  logic [NCH-1:0]    valid_in;
  logic [NCH-1:0]    mc_in;
  logic [NP-1:0]     ppv_in   [NCH];
  logic [NP-1:0]     alloc_in [NCH];

  assign flit_in[0] = bus.flit_in_0;
  assign flit_in[1] = bus.flit_in_1;
  assign flit_in[2] = bus.flit_in_2;
  assign flit_in[3] = bus.flit_in_3;
  assign valid_in   = {bus.valid_in_3, bus.valid_in_2, bus.valid_in_1, bus.valid_in_0};
  assign mc_in      = {bus.mc_3, bus.mc_2, bus.mc_1, bus.mc_0};
  assign ppv_in[0]  = bus.ppv_0;
  assign ppv_in[1]  = bus.ppv_1;
  assign ppv_in[2]  = bus.ppv_2;
  assign ppv_in[3]  = bus.ppv_3;
  assign alloc_in[0] = bus.allocPV_0;
  assign alloc_in[1] = bus.allocPV_1;
  assign alloc_in[2] = bus.allocPV_2;
  assign alloc_in[3] = bus.allocPV_3;

  // Registered state
  logic [FLIT_W-1:0] flit_q [NP];
  logic [FLIT_W-1:0] flit_d [NP];
  logic [NP-1:0]     valid_q, valid_d;
  logic [NP-1:0]     defl_q, defl_d;
  logic [CNT_W-1:0]  cnt_fwd_q, cnt_fwd_d;
  logic [CNT_W-1:0]  cnt_defl_q, cnt_defl_d;
  logic              err_conflict_q, err_conflict_d;
  logic              err_drop_q, err_drop_d;
  logic              err_mc_split_q, err_mc_split_d;

  // claim[p][i]: effective channel i has been granted port p
  logic [NCH-1:0] claim [NP];

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      for (int i = 0; i < NCH; i++) begin
        claim[p][i] = valid_in[i] & alloc_in[i][p];
      end
    end
  end

  // Crossbar. Scanning from the lowest rank upward lets the highest-ranked
  // (lowest-index) claimant overwrite everything below it.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      flit_d[p]  = flit_q[p];  // unused link holds its last flit
      valid_d[p] = 1'b0;
      defl_d[p]  = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
        if (claim[p][i]) begin
          valid_d[p] = 1'b1;
          defl_d[p]  = ~ppv_in[i][p];
          flit_d[p]  = flit_in[i];
          // Saturating bump of the deflection field on non-productive copies
          if (!ppv_in[i][p] && !(&flit_in[i][DEFL_LSB +: DEFL_W])) begin
            flit_d[p][DEFL_LSB +: DEFL_W] = flit_in[i][DEFL_LSB +: DEFL_W] + DEFL_ONE;
          end
        end
      end
    end
  end

  // Error detection for the current input set
  logic conflict_now, drop_now, split_now;

  always_comb begin
    conflict_now = 1'b0;
    drop_now     = 1'b0;
    split_now    = 1'b0;
    for (int p = 0; p < NP; p++) begin
      // More than one bit set: x & (x-1) clears the lowest set bit
      if ((claim[p] & (claim[p] - 4'd1)) != '0) conflict_now = 1'b1;
    end
    for (int i = 0; i < NCH; i++) begin
      if (valid_in[i] && (alloc_in[i] == '0)) drop_now = 1'b1;
      if (valid_in[i] && !mc_in[i] && ((alloc_in[i] & (alloc_in[i] - PV_ONE)) != '0)) begin
        split_now = 1'b1;
      end
    end
  end

  // Statistics: sum in CNT_W+3 bits so the add cannot wrap, then clamp
  logic [2:0]       n_fwd, n_defl;
  logic [CNT_W+2:0] fwd_sum, defl_sum;

  always_comb begin
    n_fwd  = 3'd0;
    n_defl = 3'd0;
    for (int p = 0; p < NP; p++) begin
      n_fwd  = n_fwd  + {2'b00, valid_d[p]};
      n_defl = n_defl + {2'b00, defl_d[p]};
    end
    fwd_sum  = {3'b000, cnt_fwd_q}  + {{CNT_W{1'b0}}, n_fwd};
    defl_sum = {3'b000, cnt_defl_q} + {{CNT_W{1'b0}}, n_defl};

    if (bus.stat_clr) begin
      // Clear takes priority over a same-cycle increment or error
      cnt_fwd_d      = '0;
      cnt_defl_d     = '0;
      err_conflict_d = 1'b0;
      err_drop_d     = 1'b0;
      err_mc_split_d = 1'b0;
    end else begin
      cnt_fwd_d      = (fwd_sum  > CNT_SAT) ? {CNT_W{1'b1}} : fwd_sum[CNT_W-1:0];
      cnt_defl_d     = (defl_sum > CNT_SAT) ? {CNT_W{1'b1}} : defl_sum[CNT_W-1:0];
      err_conflict_d = err_conflict_q | conflict_now;
      err_drop_d     = err_drop_q     | drop_now;
      err_mc_split_d = err_mc_split_q | split_now;
    end
  end

  // Datapath registers (not touched by stat_clr)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NP; p++) begin
        flit_q[p] <= '0;
      end
      valid_q <= '0;
      defl_q  <= '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        flit_q[p] <= flit_d[p];
      end
      valid_q <= valid_d;
      defl_q  <= defl_d;
    end
  end

  // Statistics and error registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_fwd_q      <= '0;
      cnt_defl_q     <= '0;
      err_conflict_q <= 1'b0;
      err_drop_q     <= 1'b0;
      err_mc_split_q <= 1'b0;
    end else begin
      cnt_fwd_q      <= cnt_fwd_d;
      cnt_defl_q     <= cnt_defl_d;
      err_conflict_q <= err_conflict_d;
      err_drop_q     <= err_drop_d;
      err_mc_split_q <= err_mc_split_d;
    end
  end

  assign bus.flit_out_0   = flit_q[0];
  assign bus.flit_out_1   = flit_q[1];
  assign bus.flit_out_2   = flit_q[2];
  assign bus.flit_out_3   = flit_q[3];
  assign bus.valid_out_0  = valid_q[0];
  assign bus.valid_out_1  = valid_q[1];
  assign bus.valid_out_2  = valid_q[2];
  assign bus.valid_out_3  = valid_q[3];
  assign bus.defl_out_0   = defl_q[0];
  assign bus.defl_out_1   = defl_q[1];
  assign bus.defl_out_2   = defl_q[2];
  assign bus.defl_out_3   = defl_q[3];
  assign bus.cnt_fwd      = cnt_fwd_q;
  assign bus.cnt_defl     = cnt_defl_q;
  assign bus.err_conflict = err_conflict_q;
  assign bus.err_drop     = err_drop_q;
  assign bus.err_mc_split = err_mc_split_q;

endmodule

// File: tb/tb_bless_sw_traversal.sv
// ---------------------------------------------------------------------------
// tb_bless_sw_traversal
//   Directed bench for bless_sw_traversal: clock/reset block, driver tasks,
//   a behavioural model compared against the DUT on every falling edge, plus
//   hand-computed literal expectations, and a final summary line.
// ---------------------------------------------------------------------------
module tb_bless_sw_traversal;

  logic clk;
  logic reset;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  bless_sw_traversal_if #(.FLIT_W(64), .CNT_W(16)) bus ();

  bless_sw_traversal #(
    .FLIT_W(64), .DEFL_LSB(56), .DEFL_W(4), .CNT_W(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- stimulus variables ----------------
  logic [63:0] t_flit  [4];
  logic        t_valid [4];
  logic        t_mc    [4];
  logic [3:0]  t_ppv   [4];
  logic [3:0]  t_alloc [4];
  logic        t_clr;

  assign bus.flit_in_0  = t_flit[0];
  assign bus.flit_in_1  = t_flit[1];
  assign bus.flit_in_2  = t_flit[2];
  assign bus.flit_in_3  = t_flit[3];
  assign bus.valid_in_0 = t_valid[0];
  assign bus.valid_in_1 = t_valid[1];
  assign bus.valid_in_2 = t_valid[2];
  assign bus.valid_in_3 = t_valid[3];
  assign bus.mc_0 = t_mc[0];
  assign bus.mc_1 = t_mc[1];
  assign bus.mc_2 = t_mc[2];
  assign bus.mc_3 = t_mc[3];
  assign bus.ppv_0 = t_ppv[0];
  assign bus.ppv_1 = t_ppv[1];
  assign bus.ppv_2 = t_ppv[2];
  assign bus.ppv_3 = t_ppv[3];
  assign bus.allocPV_0 = t_alloc[0];
  assign bus.allocPV_1 = t_alloc[1];
  assign bus.allocPV_2 = t_alloc[2];
  assign bus.allocPV_3 = t_alloc[3];
  assign bus.stat_clr  = t_clr;

  // DUT outputs as arrays for the compare loop
  logic [63:0] o_flit  [4];
  logic        o_valid [4];
  logic        o_defl  [4];
  assign o_flit[0] = bus.flit_out_0;
  assign o_flit[1] = bus.flit_out_1;
  assign o_flit[2] = bus.flit_out_2;
  assign o_flit[3] = bus.flit_out_3;
  assign o_valid[0] = bus.valid_out_0;
  assign o_valid[1] = bus.valid_out_1;
  assign o_valid[2] = bus.valid_out_2;
  assign o_valid[3] = bus.valid_out_3;
  assign o_defl[0] = bus.defl_out_0;
  assign o_defl[1] = bus.defl_out_1;
  assign o_defl[2] = bus.defl_out_2;
  assign o_defl[3] = bus.defl_out_3;

  // ---------------- scoreboard bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_p(input string name, input int p, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%h expected=%h at %0t", name, p, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [3:0][63:0] flit;
    logic [3:0]       valid;
    logic [3:0]       defl;
    logic [31:0]      fwd;
    logic [31:0]      dcnt;
    logic             conf;
    logic             drop;
    logic             split;
  } model_t;

  model_t m;

  // What the registered outputs must become after one clock with the current
  // inputs, following the link/deflection/statistics rules directly.
  function automatic model_t model_next(input model_t cur);
    model_t r;
    logic [63:0] f;
    int nv, nd, ngr;
    bit conf, drop, split;
    r = cur;
    r.valid = '0;
    r.defl  = '0;
    conf = 0; drop = 0; split = 0;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 4; i++) begin
        if (t_valid[i] && t_alloc[i][p]) begin
          if (r.valid[p]) begin
            conf = 1;  // someone of higher rank already owns the link
          end else begin
            r.valid[p] = 1'b1;
            f = t_flit[i];
            if (!t_ppv[i][p]) begin
              r.defl[p] = 1'b1;
              if (f[59:56] != 4'hF) f[59:56] = f[59:56] + 4'd1;
            end
            r.flit[p] = f;
          end
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (t_valid[i]) begin
        ngr = 0;
        for (int p = 0; p < 4; p++) if (t_alloc[i][p]) ngr++;
        if (ngr == 0) drop = 1;
        if (!t_mc[i] && ngr > 1) split = 1;
      end
    end
    nv = 0; nd = 0;
    for (int p = 0; p < 4; p++) begin
      if (r.valid[p]) nv++;
      if (r.defl[p])  nd++;
    end
    if (t_clr) begin
      r.fwd = 0; r.dcnt = 0; r.conf = 0; r.drop = 0; r.split = 0;
    end else begin
      r.fwd   = (cur.fwd + nv > 65535)  ? 65535 : cur.fwd + nv;
      r.dcnt  = (cur.dcnt + nd > 65535) ? 65535 : cur.dcnt + nd;
      r.conf  = cur.conf  | conf;
      r.drop  = cur.drop  | drop;
      r.split = cur.split | split;
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= '0;
    else        m <= model_next(m);
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (check_en) begin
      for (int p = 0; p < 4; p++) begin
        chk_p("valid_out", p, {63'd0, o_valid[p]}, {63'd0, m.valid[p]});
        chk_p("defl_out",  p, {63'd0, o_defl[p]},  {63'd0, m.defl[p]});
        chk_p("flit_out",  p, o_flit[p], m.flit[p]);
      end
      chk("cnt_fwd",      {48'd0, bus.cnt_fwd},  {32'd0, m.fwd});
      chk("cnt_defl",     {48'd0, bus.cnt_defl}, {32'd0, m.dcnt});
      chk("err_conflict", {63'd0, bus.err_conflict}, {63'd0, m.conf});
      chk("err_drop",     {63'd0, bus.err_drop},     {63'd0, m.drop});
      chk("err_mc_split", {63'd0, bus.err_mc_split}, {63'd0, m.split});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    for (int i = 0; i < 4; i++) begin
      t_flit[i]  = '0;
      t_valid[i] = 1'b0;
      t_mc[i]    = 1'b0;
      t_ppv[i]   = '0;
      t_alloc[i] = '0;
    end
    t_clr = 1'b0;
  endtask

  task automatic set_ch(input int i, input logic [63:0] f, input logic mc,
                        input logic [3:0] ppv, input logic [3:0] alloc);
    t_flit[i]  = f;
    t_valid[i] = 1'b1;
    t_mc[i]    = mc;
    t_ppv[i]   = ppv;
    t_alloc[i] = alloc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  localparam logic [63:0] F1 = 64'h0012_3456_789A_BCDE;
  localparam logic [63:0] F2 = 64'h0355_0000_1111_2222;
  localparam logic [63:0] F3 = 64'hAF00_0000_0000_00FF;
  localparam logic [63:0] F4 = 64'h0100_DEAD_BEEF_0001;
  localparam logic [63:0] FA = 64'h0000_0000_0000_00AA;
  localparam logic [63:0] FB = 64'h0000_0000_0000_00BB;
  localparam logic [63:0] FC = 64'h0000_0000_0000_00CC;
  localparam logic [63:0] FD = 64'h0200_0000_0000_00DD;
  localparam logic [63:0] FE = 64'h0000_0000_0000_00EE;

  initial begin
    reset = 1'b0;
    idle();
    #2;
    chk("reset valid_out_0", {63'd0, bus.valid_out_0}, 64'd0);
    chk("reset flit_out_0",  bus.flit_out_0, 64'd0);
    chk("reset cnt_fwd",     {48'd0, bus.cnt_fwd}, 64'd0);
    chk("reset err_drop",    {63'd0, bus.err_drop}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b1;
    check_en = 1'b1;

    // Unicast productive
    set_ch(0, F1, 1'b0, 4'b0001, 4'b0001);
    step(); idle();
    chk("uc valid_out_0", {63'd0, bus.valid_out_0}, 64'd1);
    chk("uc flit_out_0",  bus.flit_out_0, F1);
    chk("uc defl_out_0",  {63'd0, bus.defl_out_0}, 64'd0);
    chk("uc cnt_fwd",     {48'd0, bus.cnt_fwd}, 64'd1);
    chk("uc cnt_defl",    {48'd0, bus.cnt_defl}, 64'd0);
    step();
    chk("hold valid_out_0", {63'd0, bus.valid_out_0}, 64'd0);
    chk("hold flit_out_0",  bus.flit_out_0, F1);

    // Multicast with one deflected copy
    set_ch(1, F2, 1'b1, 4'b0011, 4'b0111);
    step(); idle();
    chk("mc flit_out_0", bus.flit_out_0, F2);
    chk("mc flit_out_1", bus.flit_out_1, F2);
    chk("mc flit_out_2", bus.flit_out_2, 64'h0455_0000_1111_2222);
    chk("mc defl_out_0", {63'd0, bus.defl_out_0}, 64'd0);
    chk("mc defl_out_2", {63'd0, bus.defl_out_2}, 64'd1);
    chk("mc valid_out_3", {63'd0, bus.valid_out_3}, 64'd0);
    chk("mc cnt_fwd",    {48'd0, bus.cnt_fwd}, 64'd4);
    chk("mc cnt_defl",   {48'd0, bus.cnt_defl}, 64'd1);

    // Deflection field already saturated
    set_ch(0, F3, 1'b0, 4'b0001, 4'b1000);
    step(); idle();
    chk("sat flit_out_3", bus.flit_out_3, F3);
    chk("sat defl_out_3", {63'd0, bus.defl_out_3}, 64'd1);
    chk("sat cnt_fwd",    {48'd0, bus.cnt_fwd}, 64'd5);
    chk("sat cnt_defl",   {48'd0, bus.cnt_defl}, 64'd2);

    // Invalid channel's grant is ignored
    t_flit[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    t_alloc[0] = 4'b0010;
    set_ch(2, F4, 1'b0, 4'b0010, 4'b0010);
    step(); idle();
    chk("inv flit_out_1",    bus.flit_out_1, F4);
    chk("inv err_conflict",  {63'd0, bus.err_conflict}, 64'd0);
    chk("inv cnt_fwd",       {48'd0, bus.cnt_fwd}, 64'd6);

    // Conflict on S and a dropped channel
    set_ch(0, FA, 1'b0, 4'b0100, 4'b0100);
    set_ch(2, FB, 1'b0, 4'b0100, 4'b0100);
    set_ch(3, FC, 1'b0, 4'b0001, 4'b0000);
    step(); idle();
    chk("cf flit_out_2",   bus.flit_out_2, FA);
    chk("cf err_conflict", {63'd0, bus.err_conflict}, 64'd1);
    chk("cf err_drop",     {63'd0, bus.err_drop}, 64'd1);
    chk("cf err_mc_split", {63'd0, bus.err_mc_split}, 64'd0);
    chk("cf cnt_fwd",      {48'd0, bus.cnt_fwd}, 64'd7);
    step();
    chk("sticky err_conflict", {63'd0, bus.err_conflict}, 64'd1);
    chk("sticky err_drop",     {63'd0, bus.err_drop}, 64'd1);

    // Unicast granted two ports
    set_ch(1, FD, 1'b0, 4'b0011, 4'b0011);
    step(); idle();
    chk("split err_mc_split", {63'd0, bus.err_mc_split}, 64'd1);
    chk("split valid_out_1",  {63'd0, bus.valid_out_1}, 64'd1);
    chk("split cnt_fwd",      {48'd0, bus.cnt_fwd}, 64'd9);

    // stat_clr alone
    t_clr = 1'b1;
    step(); idle();
    chk("clr cnt_fwd",      {48'd0, bus.cnt_fwd}, 64'd0);
    chk("clr cnt_defl",     {48'd0, bus.cnt_defl}, 64'd0);
    chk("clr err_conflict", {63'd0, bus.err_conflict}, 64'd0);
    chk("clr err_drop",     {63'd0, bus.err_drop}, 64'd0);
    chk("clr err_mc_split", {63'd0, bus.err_mc_split}, 64'd0);

    // stat_clr wins over same-cycle increment and error
    t_clr = 1'b1;
    set_ch(0, FE, 1'b1, 4'b0011, 4'b0011);
    set_ch(3, FC, 1'b0, 4'b0001, 4'b0000);
    step(); idle();
    chk("clrinc cnt_fwd",     {48'd0, bus.cnt_fwd}, 64'd0);
    chk("clrinc valid_out_0", {63'd0, bus.valid_out_0}, 64'd1);
    chk("clrinc valid_out_1", {63'd0, bus.valid_out_1}, 64'd1);
    chk("clrinc err_drop",    {63'd0, bus.err_drop}, 64'd0);

    // Counter saturation: 16383 x 4 copies, then +2, then +4
    set_ch(0, FE, 1'b1, 4'b1111, 4'b1111);
    repeat (16383) step();
    chk("cnt_fwd FFFC", {48'd0, bus.cnt_fwd}, 64'h0000_0000_0000_FFFC);
    t_ppv[0] = 4'b0011;
    t_alloc[0] = 4'b0011;
    step();
    chk("cnt_fwd FFFE", {48'd0, bus.cnt_fwd}, 64'h0000_0000_0000_FFFE);
    t_ppv[0] = 4'b1111;
    t_alloc[0] = 4'b1111;
    step();
    chk("cnt_fwd sat", {48'd0, bus.cnt_fwd}, 64'h0000_0000_0000_FFFF);
    step();
    chk("cnt_fwd stay sat", {48'd0, bus.cnt_fwd}, 64'h0000_0000_0000_FFFF);
    chk("cnt_defl zero",    {48'd0, bus.cnt_defl}, 64'd0);

    // Asynchronous reset in the middle of traffic
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("areset valid_out_0", {63'd0, bus.valid_out_0}, 64'd0);
    chk("areset flit_out_0",  bus.flit_out_0, 64'd0);
    chk("areset cnt_fwd",     {48'd0, bus.cnt_fwd}, 64'd0);
    chk("areset err_drop",    {63'd0, bus.err_drop}, 64'd0);
    idle();
    set_ch(0, F1, 1'b0, 4'b0001, 4'b0001);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("release before edge", {63'd0, bus.valid_out_0}, 64'd0);
    step(); idle();
    chk("release valid_out_0", {63'd0, bus.valid_out_0}, 64'd1);
    chk("release flit_out_0",  bus.flit_out_0, F1);
    chk("release cnt_fwd",     {48'd0, bus.cnt_fwd}, 64'd1);
    step();
    step();

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
